collision_scorer: RTL and testbench

- Parametrised game-rule engine for the LED-matrix Flappy Bird.
- Compares the bird plane against the pipe plane once per frame tick and detects pipe-passes for scoring.
- Runs a lives/invulnerability state machine and keeps a saturating BCD score.
- Sits between the frame/scroll logic that drives both planes and the display/score logic.

---
 rtl/collision_scorer.sv | 210 +++++++++++++++++++++
 tb/tb_collision_scorer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scorer.sv
// rtl/collision_scorer.sv - Flappy Bird collision detection, pass scoring and lives/grace state machine
//
// Purpose: once per frame tick, compares the bird plane against the pipe plane
// to detect collisions, and detects pipes leaving the bird column to award points.
// Runs the IDLE/PLAY/GRACE/DEAD game state machine and keeps a saturating BCD score.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   start      in   level; begins a game from IDLE or DEAD
//   tick       in   one-cycle frame-advance strobe; all evaluation happens on tick
//   bird       in   [ROWS-1:0][COLS-1:0] bird plane, cell (r,c) = bird[r][c]
//   pipe       in   [ROWS-1:0][COLS-1:0] pipe plane, same indexing
//   state      out  2'b00 IDLE, 2'b01 PLAY, 2'b10 GRACE, 2'b11 DEAD
//   gameover   out  high while state == DEAD
//   hit        out  one-cycle pulse per registered collision
//   add_point  out  one-cycle pulse per scored pass
//   score      out  BCD score, digit 0 in bits [3:0]
//   lives_left out  remaining lives
//   invuln     out  high while state == GRACE
module collision_scorer #(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int BIRD_COL     = 14,
    parameter int FLOOR_ROW    = ROWS - 1,
    parameter int FLOOR_KILLS  = 1,
    parameter int LIVES        = 3,
    parameter int GRACE_TICKS  = 8,
    parameter int SCORE_DIGITS = 2,
    localparam int LW          = $clog2(LIVES + 1),
    localparam int GW          = $clog2(GRACE_TICKS + 1),
    localparam int SW          = 4 * SCORE_DIGITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      tick,
    input  logic [ROWS-1:0][COLS-1:0] bird,
    input  logic [ROWS-1:0][COLS-1:0] pipe,
    output logic [1:0]                state,
    output logic                      gameover,
    output logic                      hit,
    output logic                      add_point,
    output logic [SW-1:0]             score,
    output logic [LW-1:0]             lives_left,
    output logic                      invuln
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_GRACE = 2'b10,
        S_DEAD  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] score_q, score_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [GW-1:0] grace_q, grace_d;
    logic          hist_q, hist_d;
    logic          hit_q, hit_d;
    logic          add_q, add_d;
    logic          gameover_q;
    logic          invuln_q;

    logic          coll;
    logic          pipe_at_bird;
    logic          pass;
    logic [SW-1:0] score_inc;
    logic [SW-1:0] score_sat;
    logic          inc_carry;

    // Plane comparison: any overlapping cell, plus the ground row when enabled.
    always_comb begin
        coll         = 1'b0;
        pipe_at_bird = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            coll         = coll | (|(bird[r] & pipe[r]));
            pipe_at_bird = pipe_at_bird | pipe[r][BIRD_COL];
        end
        if (FLOOR_KILLS != 0) begin
            coll = coll | (|bird[FLOOR_ROW]);
        end
    end

    // A pass is the tick on which the bird column goes from occupied to empty.
    assign pass = tick & hist_q & ~pipe_at_bird;

    // BCD ripple increment; a carry out of the top digit means the score is
    // already all-9s, so the old value is kept instead of wrapping.
    always_comb begin
        score_inc = score_q;
        inc_carry = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (inc_carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    inc_carry           = 1'b0;
                end
            end
        end
        score_sat = inc_carry ? score_q : score_inc;
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        grace_d = grace_q;
        hist_d  = hist_q;
        hit_d   = 1'b0;
        add_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                score_d = '0;
                lives_d = LW'(LIVES);
                if (start) begin
                    state_d = S_PLAY;
                    hist_d  = 1'b0;
                end
            end

            S_PLAY: begin
                if (tick) begin
                    hist_d = pipe_at_bird;
                    if (coll) begin
                        hit_d = 1'b1;
                        if (lives_q != '0) begin
                            lives_d = lives_q - LW'(1);
                        end
                        if (lives_q <= LW'(1)) begin
                            state_d = S_DEAD;
                        end else begin
                            state_d = S_GRACE;
                            grace_d = GW'(GRACE_TICKS);
                        end
                    end else if (pass) begin
                        add_d   = 1'b1;
                        score_d = score_sat;
                    end
                end
            end

            S_GRACE: begin
                // Collisions are ignored here; the tick that empties the
                // counter is still invulnerable and only then returns to PLAY.
                if (tick) begin
                    hist_d = pipe_at_bird;
                    if (pass) begin
                        add_d   = 1'b1;
                        score_d = score_sat;
                    end
                    grace_d = grace_q - GW'(1);
                    if (grace_q <= GW'(1)) begin
                        state_d = S_PLAY;
                    end
                end
            end

            S_DEAD: begin
                if (start) begin
                    state_d = S_PLAY;
                    score_d = '0;
                    lives_d = LW'(LIVES);
                    hist_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            score_q    <= '0;
            lives_q    <= LW'(LIVES);
            grace_q    <= '0;
            hist_q     <= 1'b0;
            hit_q      <= 1'b0;
            add_q      <= 1'b0;
            gameover_q <= 1'b0;
            invuln_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            grace_q    <= grace_d;
            hist_q     <= hist_d;
            hit_q      <= hit_d;
            add_q      <= add_d;
            gameover_q <= (state_d == S_DEAD);
            invuln_q   <= (state_d == S_GRACE);
        end
    end

    assign state      = state_q;
    assign gameover   = gameover_q;
    assign hit        = hit_q;
    assign add_point  = add_q;
    assign score      = score_q;
    assign lives_left = lives_q;
    assign invuln     = invuln_q;

endmodule

// File: tb/tb_collision_scorer.sv
// tb/tb_collision_scorer.sv - self-checking bench for collision_scorer
module tb_collision_scorer;

    localparam int ROWS      = 16;
    localparam int COLS      = 16;
    localparam int BIRD_COL  = 14;
    localparam int FLOOR_ROW = ROWS - 1;
    localparam int LIVES     = 3;
    localparam int GRACE     = 8;
    localparam int MAXSCORE  = 99;

    localparam int P_IDLE  = 0;
    localparam int P_PLAY  = 1;
    localparam int P_GRACE = 2;
    localparam int P_DEAD  = 3;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      start;
    logic                      tick;
    logic [ROWS-1:0][COLS-1:0] bird;
    logic [ROWS-1:0][COLS-1:0] pipe;
    logic [1:0]                state_w;
    logic                      gameover_w;
    logic                      hit_w;
    logic                      add_w;
    logic [7:0]                score_w;
    logic [1:0]                lives_w;
    logic                      invuln_w;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state in plain game terms.
    int m_st, m_lives, m_score, m_grace, m_hist, m_hit, m_add;

    always #5 clk = ~clk;

    collision_scorer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tick       (tick),
        .bird       (bird),
        .pipe       (pipe),
        .state      (state_w),
        .gameover   (gameover_w),
        .hit        (hit_w),
        .add_point  (add_w),
        .score      (score_w),
        .lives_left (lives_w),
        .invuln     (invuln_w)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int to_bcd(input int s);
        return (s / 10) * 16 + (s % 10);
    endfunction

    task automatic model_step();
        int crash, at_col, scored;
        crash  = 0;
        at_col = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (bird[r][c] && pipe[r][c]) crash = 1;
            end
            if (pipe[r][BIRD_COL]) at_col = 1;
        end
        for (int c = 0; c < COLS; c++) begin
            if (bird[FLOOR_ROW][c]) crash = 1;
        end
        if (reset) begin
            m_st = P_IDLE; m_lives = LIVES; m_score = 0; m_grace = 0;
            m_hist = 0; m_hit = 0; m_add = 0;
        end else begin
            m_hit  = 0;
            m_add  = 0;
            scored = (tick && m_hist == 1 && at_col == 0) ? 1 : 0;
            if (m_st == P_IDLE || m_st == P_DEAD) begin
                if (start) begin
                    m_st = P_PLAY; m_score = 0; m_lives = LIVES; m_hist = 0;
                end
            end else if (tick) begin
                if (m_st == P_PLAY && crash == 1) begin
                    m_hit   = 1;
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_st = P_DEAD;
                    else begin m_st = P_GRACE; m_grace = GRACE; end
                end else begin
                    if (scored == 1) begin
                        m_add   = 1;
                        m_score = (m_score < MAXSCORE) ? m_score + 1 : MAXSCORE;
                    end
                    if (m_st == P_GRACE) begin
                        m_grace = m_grace - 1;
                        if (m_grace == 0) m_st = P_PLAY;
                    end
                end
                m_hist = at_col;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", int'(state_w), m_st);
            check("gameover", int'(gameover_w), (m_st == P_DEAD) ? 1 : 0);
            check("invuln", int'(invuln_w), (m_st == P_GRACE) ? 1 : 0);
            check("hit", int'(hit_w), m_hit);
            check("add_point", int'(add_w), m_add);
            check("score", int'(score_w), to_bcd(m_score));
            check("lives", int'(lives_w), m_lives);
        end
    end

    task automatic cycle(input logic tk, input logic st);
        tick  = tk;
        start = st;
        @(posedge clk);
        #2;
        tick  = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // Pipe enters the bird column for two ticks, then leaves on the third.
    task automatic pass_once();
        bird = '0;
        pipe = '0;
        pipe[3][BIRD_COL] = 1'b1;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        pipe = '0;
        cycle(1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        tick  = 1'b0;
        bird  = '0;
        pipe  = '0;
        @(posedge clk);
        #2;
        cycle(1'b0, 1'b0);
        chk_en = 1'b1;
        reset  = 1'b0;
        check("lit_reset_state", int'(state_w), 0);
        check("lit_reset_lives", int'(lives_w), 3);
        check("lit_reset_score", int'(score_w), 0);

        // Hit, grace window, second hit.
        cycle(1'b0, 1'b1);
        check("lit_start_state", int'(state_w), 1);
        bird[5][BIRD_COL] = 1'b1;
        pipe[5][BIRD_COL] = 1'b1;
        cycle(1'b1, 1'b0);
        check("lit_hit1", int'(hit_w), 1);
        check("lit_lives2", int'(lives_w), 2);
        check("lit_grace_state", int'(state_w), 2);
        check("lit_invuln", int'(invuln_w), 1);
        cycle(1'b0, 1'b1);
        check("lit_start_in_grace", int'(state_w), 2);
        for (int i = 0; i < GRACE; i++) begin
            cycle(1'b1, 1'b0);
            check("lit_grace_nohit", int'(hit_w), 0);
            check("lit_grace_st", int'(state_w), (i < GRACE - 1) ? 2 : 1);
            cycle(1'b0, 1'b0);
        end
        check("lit_grace_lives", int'(lives_w), 2);
        cycle(1'b1, 1'b0);
        check("lit_lives1", int'(lives_w), 1);

        // Passes, BCD carry and saturation.
        do_reset();
        cycle(1'b0, 1'b1);
        pass_once();
        check("lit_pass1_add", int'(add_w), 1);
        check("lit_score01", int'(score_w), 8'h01);
        for (int i = 1; i < 10; i++) pass_once();
        check("lit_score10", int'(score_w), 8'h10);
        for (int i = 10; i < 99; i++) pass_once();
        check("lit_score99", int'(score_w), 8'h99);
        pass_once();
        check("lit_sat_add", int'(add_w), 1);
        check("lit_sat_score", int'(score_w), 8'h99);

        // Collision and pass on the same tick: collision wins.
        pipe[3][BIRD_COL] = 1'b1;
        cycle(1'b1, 1'b0);
        pipe = '0;
        bird = '0;
        pipe[5][10] = 1'b1;
        bird[5][10] = 1'b1;
        cycle(1'b1, 1'b0);
        check("lit_both_hit", int'(hit_w), 1);
        check("lit_both_add", int'(add_w), 0);
        check("lit_both_score", int'(score_w), 8'h99);

        // Floor deaths, DEAD freeze, restart.
        do_reset();
        cycle(1'b0, 1'b1);
        pass_once();
        pass_once();
        bird = '0;
        pipe = '0;
        bird[FLOOR_ROW][BIRD_COL] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0);
            check("lit_floor_lives", int'(lives_w), 2 - k);
            if (k < 2) begin
                for (int g = 0; g < GRACE; g++) cycle(1'b1, 1'b0);
            end
        end
        check("lit_dead_state", int'(state_w), 3);
        check("lit_gameover", int'(gameover_w), 1);
        cycle(1'b1, 1'b0);
        check("lit_dead_score", int'(score_w), 8'h02);
        cycle(1'b0, 1'b1);
        check("lit_restart_state", int'(state_w), 1);
        check("lit_restart_score", int'(score_w), 0);
        check("lit_restart_lives", int'(lives_w), 3);

        // Reset during GRACE.
        do_reset();
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) pass_once();
        check("lit_score05", int'(score_w), 8'h05);
        bird[5][BIRD_COL] = 1'b1;
        pipe[5][BIRD_COL] = 1'b1;
        cycle(1'b1, 1'b0);
        check("lit_pre_reset_grace", int'(state_w), 2);
        do_reset();
        check("lit_rst_state", int'(state_w), 0);
        check("lit_rst_score", int'(score_w), 0);
        check("lit_rst_lives", int'(lives_w), 3);
        check("lit_rst_invuln", int'(invuln_w), 0);
        cycle(1'b1, 1'b0);
        check("lit_idle_tick_state", int'(state_w), 0);
        check("lit_idle_tick_hit", int'(hit_w), 0);
        cycle(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
